// File: rtl/alu_cmd_sequencer.sv
// Command initiator and checker for the 8-bit combinational ALU: one command in flight,
// operands held for SETTLE cycles, ALU outputs captured, compared to a golden model and returned.
module alu_cmd_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_tag,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic [3:0]  rsp_tag,
  output logic        rsp_mismatch,
  output logic [7:0]  err_count,
  output logic [15:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic        accept, capture, complete;
  logic [3:0]  cnt_reg;
  logic [3:0]  tag_reg;
  logic [7:0]  a_reg, b_reg;
  logic [2:0]  op_reg;
  logic [7:0]  res_reg;
  logic        carry_reg, zero_reg, mism_reg;
  logic [3:0]  rsp_tag_reg;
  logic [7:0]  err_reg;
  logic [15:0] cnt_cmd_reg;

  logic [8:0]  gold_wide;
  logic [7:0]  gold_res;
  logic        gold_carry;
  logic        mismatch_now;

  // Golden ALU evaluated on the operands currently being driven.
  always_comb begin
    gold_wide  = '0;
    gold_res   = '0;
    gold_carry = 1'b0;
    case (op_reg)
      3'b000: begin
        gold_wide  = {1'b0, a_reg} + {1'b0, b_reg};
        gold_res   = gold_wide[7:0];
        gold_carry = gold_wide[8];
      end
      3'b001: begin
        gold_wide  = {1'b0, a_reg} - {1'b0, b_reg};
        gold_res   = gold_wide[7:0];
        gold_carry = gold_wide[8];
      end
      3'b010: gold_res = a_reg & b_reg;
      3'b011: gold_res = a_reg | b_reg;
      3'b100: gold_res = a_reg ^ b_reg;
      3'b101: gold_res = ~a_reg;
      3'b110: begin
        gold_wide  = {1'b0, a_reg} + 9'd1;
        gold_res   = gold_wide[7:0];
        gold_carry = gold_wide[8];
      end
      default: begin
        gold_wide  = {1'b0, a_reg} - 9'd1;
        gold_res   = gold_wide[7:0];
        gold_carry = gold_wide[8];
      end
    endcase
  end

  assign mismatch_now = (alu_result != gold_res) || (alu_carry != gold_carry) ||
                        (alu_zero != (gold_res == 8'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      tag_reg     <= '0;
      cnt_reg     <= '0;
      res_reg     <= '0;
      carry_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      mism_reg    <= 1'b0;
      rsp_tag_reg <= '0;
      err_reg     <= '0;
      cnt_cmd_reg <= '0;
    end else begin
      if (accept) begin
        a_reg   <= cmd_a;
        b_reg   <= cmd_b;
        op_reg  <= cmd_op;
        tag_reg <= cmd_tag;
        cnt_reg <= SETTLE_LOAD;
      end else if (state_reg == DRIVE && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture) begin
        res_reg     <= alu_result;
        carry_reg   <= alu_carry;
        zero_reg    <= alu_zero;
        mism_reg    <= mismatch_now;
        rsp_tag_reg <= tag_reg;
      end
      if (complete) begin
        cnt_cmd_reg <= cnt_cmd_reg + 16'd1;
        if (mism_reg && err_reg != 8'hFF) begin
          err_reg <= err_reg + 8'd1;
        end
      end
    end
  end

  // Gated by rst so nothing is offered during the reset cycle.
  assign cmd_ready    = (state_reg == IDLE) && !rst;
  assign rsp_valid    = (state_reg == RESP);
  assign alu_a        = a_reg;
  assign alu_b        = b_reg;
  assign alu_op       = op_reg;
  assign rsp_result   = res_reg;
  assign rsp_carry    = carry_reg;
  assign rsp_zero     = zero_reg;
  assign rsp_tag      = rsp_tag_reg;
  assign rsp_mismatch = mism_reg;
  assign err_count    = err_reg;
  assign cmd_count    = cnt_cmd_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: SETTLE=1 and SETTLE=4 sequencers driving behavioural ALU models
// (ideal, fault-injecting, and 3-cycle delayed), compared against an arithmetic reference.
module tb_alu_cmd_sequencer;

  localparam int S1 = 1;
  localparam int S4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result, err_count;
  logic [2:0]  cmd_op, alu_op;
  logic [3:0]  cmd_tag, rsp_tag;
  logic        alu_carry, alu_zero, rsp_carry, rsp_zero, rsp_mismatch;
  logic [15:0] cmd_count;

  // SETTLE=4 instance
  logic        cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4;
  logic [7:0]  cmd_a4, cmd_b4, alu_a4, alu_b4, alu_result4, rsp_result4, err_count4;
  logic [2:0]  cmd_op4, alu_op4;
  logic [3:0]  cmd_tag4, rsp_tag4;
  logic        alu_carry4, alu_zero4, rsp_carry4, rsp_zero4, rsp_mismatch4;
  logic [15:0] cmd_count4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] fault_mask = 8'h00;
  logic       slow_sel = 1'b0;
  logic [7:0] prev_a = 0, prev_b = 0;
  logic [2:0] prev_op = 0;
  int exp_cmd = 0;
  int exp_err = 0;

  alu_cmd_sequencer #(.SETTLE(S1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .rsp_mismatch(rsp_mismatch), .err_count(err_count), .cmd_count(cmd_count)
  );

  alu_cmd_sequencer #(.SETTLE(S4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_a(cmd_a4), .cmd_b(cmd_b4),
    .cmd_op(cmd_op4), .cmd_tag(cmd_tag4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4),
    .alu_result(alu_result4), .alu_carry(alu_carry4), .alu_zero(alu_zero4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_carry(rsp_carry4), .rsp_zero(rsp_zero4), .rsp_tag(rsp_tag4),
    .rsp_mismatch(rsp_mismatch4), .err_count(err_count4), .cmd_count(cmd_count4)
  );

  // Reference ALU in plain integer arithmetic: returns {zero, carry, result}.
  function automatic logic [9:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    int x;
    logic c;
    case (op)
      3'd0: x = int'(a) + int'(b);
      3'd1: x = int'(a) - int'(b);
      3'd2: x = int'(a) & int'(b);
      3'd3: x = int'(a) | int'(b);
      3'd4: x = int'(a) ^ int'(b);
      3'd5: x = 255 - int'(a);
      3'd6: x = int'(a) + 1;
      default: x = int'(a) - 1;
    endcase
    if (op == 3'd0 || op == 3'd6) c = (x > 255);
    else if (op == 3'd1 || op == 3'd7) c = (x < 0);
    else c = 1'b0;
    return {(x[7:0] == 8'd0), c, x[7:0]};
  endfunction

  // Delayed ALU models: outputs reflect inputs from three edges earlier.
  logic [18:0] p1_q [3];
  logic [18:0] p4_q [3];
  always @(posedge clk) begin
    p1_q[0] <= {alu_a, alu_b, alu_op};
    p1_q[1] <= p1_q[0];
    p1_q[2] <= p1_q[1];
    p4_q[0] <= {alu_a4, alu_b4, alu_op4};
    p4_q[1] <= p4_q[0];
    p4_q[2] <= p4_q[1];
  end

  logic [9:0] fast1, slow1, slow4;
  assign fast1       = ref_alu(alu_a, alu_b, alu_op);
  assign slow1       = ref_alu(p1_q[2][18:11], p1_q[2][10:3], p1_q[2][2:0]);
  assign slow4       = ref_alu(p4_q[2][18:11], p4_q[2][10:3], p4_q[2][2:0]);
  assign alu_result  = slow_sel ? slow1[7:0] : (fast1[7:0] ^ fault_mask);
  assign alu_carry   = slow_sel ? slow1[8] : fast1[8];
  assign alu_zero    = slow_sel ? slow1[9] : fast1[9];
  assign alu_result4 = slow4[7:0];
  assign alu_carry4  = slow4[8];
  assign alu_zero4   = slow4[9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_cmd_ready", cmd_ready, 0);
  endtask

  // One complete transaction on the SETTLE=1 instance, started at a negedge in IDLE.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input int stall, input bit poke);
    logic [9:0] gold, seen;
    logic mm;
    int cyc;
    gold = ref_alu(a, b, op);
    if (slow_sel) seen = ref_alu(prev_a, prev_b, prev_op);
    else begin
      seen = gold;
      seen[7:0] = gold[7:0] ^ fault_mask;
    end
    mm = (seen != gold);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op);
    check("cmd_ready_drive", cmd_ready, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, S1);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == stall / 2) begin
        cmd_valid = 1'b1; cmd_a = ~a; cmd_b = ~b; cmd_op = op + 3'd1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, seen[7:0]);
    end
    if (poke) check("alu_a_held", alu_a, a);
    check("rsp_result", rsp_result, seen[7:0]);
    check("rsp_carry", rsp_carry, seen[8]);
    check("rsp_zero", rsp_zero, seen[9]);
    check("rsp_tag", rsp_tag, tag);
    check("rsp_mismatch", rsp_mismatch, mm);
    check("cmd_ready_resp", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cmd++;
    if (mm && exp_err != 255) exp_err++;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("cmd_count", cmd_count, exp_cmd);
    check("err_count", err_count, exp_err);
    prev_a = a; prev_b = b; prev_op = op;
    $display("txn op=%0d a=%02h b=%02h tag=%0d -> res=%02h c=%0b z=%0b mm=%0b cnt=%0d err=%0d",
             op, a, b, tag, rsp_result, rsp_carry, rsp_zero, rsp_mismatch, cmd_count, err_count);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] g4;
    int cyc;
    rst = 1'b1;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; cmd_tag = 0; rsp_ready = 0;
    cmd_valid4 = 0; cmd_a4 = 0; cmd_b4 = 0; cmd_op4 = 0; cmd_tag4 = 0; rsp_ready4 = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    // Reset while in DRIVE
    cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 3'd0; cmd_tag = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("drive_alu_a", alu_a, 8'h12);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    check("no_rsp_after_drive_rst", rsp_valid, 0);
    check("ready_after_drive_rst", cmd_ready, 1);

    // Reset while in RESP
    cmd_valid = 1'b1; cmd_a = 8'h56; cmd_b = 8'h01; cmd_op = 3'd0; cmd_tag = 4'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("resp_before_rst", rsp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    check("no_rsp_after_resp_rst", rsp_valid, 0);
    check("count_after_resp_rst", cmd_count, 0);

    send(8'h01, 8'hFF, 3'd0, 4'd1, 0, 1'b0);
    send(8'h0A, 8'h05, 3'd0, 4'd3, 0, 1'b0);
    send(8'h0A, 8'h03, 3'd1, 4'd4, 0, 1'b0);
    send(8'hAA, 8'h55, 3'd4, 4'd5, 0, 1'b0);
    send(8'hA5, 8'h00, 3'd5, 4'd6, 0, 1'b0);
    send(8'h01, 8'h00, 3'd7, 4'd7, 0, 1'b0);
    send(8'hFF, 8'h00, 3'd6, 4'd8, 0, 1'b0);
    send(8'hFF, 8'h0F, 3'd2, 4'd2, 10, 1'b1);

    // Fault injection until err_count saturates
    fault_mask = 8'h01;
    send(8'hF0, 8'h0F, 3'd3, 4'd10, 0, 1'b0);
    for (int i = 1; i < 300; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom), 0, 1'b0);
    end
    check("err_saturated", err_count, 8'hFF);
    fault_mask = 8'h00;

    // Delayed ALU against SETTLE=1: stale outputs must be flagged
    send(8'h01, 8'h01, 3'd0, 4'd11, 0, 1'b0);
    repeat (4) @(negedge clk);
    slow_sel = 1'b1;
    send(8'h10, 8'h20, 3'd0, 4'd12, 0, 1'b0);
    check("slow_settle1_mismatch", rsp_mismatch, 1);
    slow_sel = 1'b0;

    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom),
           int'($urandom_range(0, 3)), 1'b0);
    end

    // SETTLE=4 instance against the delayed ALU
    for (int i = 0; i < 20; i++) begin
      cmd_a4 = 8'($urandom); cmd_b4 = 8'($urandom);
      cmd_op4 = 3'($urandom); cmd_tag4 = 4'($urandom);
      g4 = ref_alu(cmd_a4, cmd_b4, cmd_op4);
      check("s4_ready", cmd_ready4, 1);
      cmd_valid4 = 1'b1;
      @(negedge clk);
      cmd_valid4 = 1'b0;
      cyc = 0;
      while (!rsp_valid4 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("s4_latency", cyc, S4);
      check("s4_result", rsp_result4, g4[7:0]);
      check("s4_carry", rsp_carry4, g4[8]);
      check("s4_zero", rsp_zero4, g4[9]);
      check("s4_tag", rsp_tag4, cmd_tag4);
      check("s4_mismatch", rsp_mismatch4, 0);
      rsp_ready4 = 1'b1;
      @(negedge clk);
      rsp_ready4 = 1'b0;
      check("s4_cmd_count", cmd_count4, i + 1);
      check("s4_err_count", err_count4, 0);
      $display("txn4 op=%0d a=%02h b=%02h -> res=%02h c=%0b z=%0b mm=%0b",
               cmd_op4, cmd_a4, cmd_b4, rsp_result4, rsp_carry4, rsp_zero4, rsp_mismatch4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
